ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Initiator-side controller for the team's 32x32 single-port-write / registered-read-address RAM (ports clk, we, r_addr, r_data, w_addr, w_data).
- Accepts word requests from the CPU datapath over a valid/ready handshake and drives the RAM write and read ports.
- Absorbs the RAM's one-cycle read-address latency and returns read data on a response channel with backpressure.
- Also supports burst reads and burst fills; burst fills are used for memory clear and init.

Parameters:
- AW, 5, address width; must match the RAM's address width.
- DW, 32, data width; must match the RAM's data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = write/fill, 0 = read.
- req_addr  in  AW  start address.
- req_len  in  AW  burst length minus 1 (0 = single word, 31 = 32 words).
- req_wdata  in  DW  write/fill data.
- rsp_valid  out  1  read data valid.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  DW  read data (wired from ram_r_data).
- rsp_last  out  1  final beat of a read burst.
- busy  out  1  high whenever state is not IDLE.
- ram_we  out  1  to RAM we.
- ram_w_addr  out  AW  to RAM w_addr.
- ram_w_data  out  DW  to RAM w_data.
- ram_r_addr  out  AW  to RAM r_addr.
- ram_r_data  in  DW  from RAM r_data.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; cur_addr = 0; remain = 0.
  - rsp_valid = 0, rsp_last = 0, ram_we = 0, busy = 0, req_ready = 1 after release.
- States: IDLE, FILL, RD_ISSUE, RD_DATA.
- Accepting a request:
  - Accept occurs at an edge where req_valid and req_ready are both high.
  - The controller latches cur_addr = req_addr, remain = req_len and fill data = req_wdata.
- Write/fill, req_we = 1:
  - Single word (req_len = 0): the write is combinational pass-through in IDLE. ram_we = req_valid and req_we; ram_w_addr = req_addr; ram_w_data = req_wdata. The RAM commits at the accept edge. State stays IDLE, so the next request can be accepted on the very next cycle.
  - Burst (req_len > 0): the word at req_addr is written at the accept edge, then state goes to FILL with cur_addr = req_addr + 1 and remain = req_len - 1.
  - In FILL: ram_we = 1, ram_w_addr = cur_addr, and the latched fill data is written. Each cycle cur_addr increments and remain decrements. Exit to IDLE after the edge that writes with remain = 0.
  - A fill of length len+1 therefore occupies len+1 cycles.
- Read, req_we = 0:
  - The accept edge moves state to RD_ISSUE.
  - In RD_ISSUE: ram_r_addr = cur_addr and rsp_valid = 0. Next state is RD_DATA.
  - In RD_DATA: rsp_valid = 1, rsp_data = ram_r_data, rsp_last = (remain == 0).
  - ram_r_addr comes from a combinational mux:
    - cur_addr + 1 when rsp_valid and rsp_ready and remain != 0 (the pipelined advance);
    - cur_addr otherwise.
  - On a handshake with remain != 0: cur_addr increments and remain decrements. This sustains one beat per cycle.
  - On a handshake with remain = 0: state goes to IDLE.
  - rsp_ready low: the address is held, the RAM re-reads the same word, and rsp_data stays stable.
- Latency:
  - First read beat is valid in the 2nd cycle after the accept edge (one RD_ISSUE cycle).
  - A single-word write commits at the accept edge.
- Address arithmetic: modulo 2^AW; 31 + 1 wraps to 0 for both reads and fills.
- ram_we is 0 in RD_ISSUE and RD_DATA.
- Write-first hazard: when a write and a registered read address coincide, the RAM returns the new data. Since no write occurs during reads, this needs no forwarding.
- Unused outputs: ram_w_addr and ram_w_data are don't-care when ram_we = 0. In IDLE, ram_r_addr = req_addr.
- Reset mid-operation: the FSM is aborted immediately. Any partial fill remains in the RAM; an outstanding read burst is dropped and no further beats are produced.
- Requests presented while busy are ignored (req_ready = 0) and must be held by the source.

Decomposition:
- Shared package (mem_pkg):
  - state enum {IDLE, FILL, RD_ISSUE, RD_DATA};
  - AW/DW defaults;
  - constant MEM_WORDS = 2^AW.
- No sub-module required. An optional addr_counter (load, inc, wrapping, with remain down-counter and zero flag) is the only natural split.

Test Plan:
- Single write then read:
  - write addr 3 data 32'hDEADBEEF, then read addr 3 len 0;
  - required: ram_we pulses 1 cycle; rsp_valid 2 cycles after the read accept with data DEADBEEF and rsp_last = 1.
- Burst fill with wrap:
  - fill addr 30 len 3 data 32'h0000A5A5;
  - required: addresses 30, 31, 0, 1 written; busy for 3 cycles after accept; a read burst addr 30 len 3 returns 4 x A5A5.
- Streaming read:
  - preload mem[i] = i; read addr 0 len 31 with rsp_ready = 1;
  - required: 32 consecutive beats 0..31, one per cycle; rsp_last only on beat 31.
- Backpressure:
  - read addr 4 len 2; deassert rsp_ready for 3 cycles on beat 1;
  - required: rsp_data holds mem[5] and rsp_valid stays 1; then beats continue with mem[6] and last.
- Reset abort:
  - assert rst asynchronously in the middle of a read of len 7;
  - required: rsp_valid drops immediately, state is IDLE, req_ready = 1 after release, and the next request is served normally.
- Busy gating:
  - present a write while a read burst is active;
  - required: req_ready = 0 and ram_we stays 0 until the burst completes; the write is accepted in the cycle after the last beat.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
// ram_access_ctrl_pkg: shared types and defaults for the RAM access controller.
package ram_access_ctrl_pkg;
  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;
  localparam int MEM_WORDS = 1 << AW_DEF;
  typedef enum logic [1:0] {IDLE, FILL, RD_ISSUE, RD_DATA} state_t;
endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: valid/ready front end for a registered-read-address RAM with burst read and fill.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data
);
  state_t state;
  logic [AW-1:0] cur_addr, remain, cur_next;
  logic [DW-1:0] fill_data;
  logic acc, hs, rem_zero;
  always_comb begin
    acc = req_valid && req_ready;
    hs = rsp_valid && rsp_ready;
    rem_zero = remain == '0;
    cur_next = cur_addr + 1'b1;
    req_ready = state == IDLE;
    busy = state != IDLE;
    rsp_valid = state == RD_DATA;
    rsp_last = rsp_valid && rem_zero;
    rsp_data = ram_r_data;
    ram_we = (state == IDLE && req_valid && req_we) || state == FILL;
    ram_w_addr = state == FILL ? cur_addr : req_addr;
    ram_w_data = state == FILL ? fill_data : req_wdata;
    // presenting the next address on a handshake keeps reads at one beat per cycle
    ram_r_addr = state == IDLE ? req_addr : (hs && !rem_zero) ? cur_next : cur_addr;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur_addr <= '0;
      remain <= '0;
      fill_data <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          fill_data <= req_wdata;
          if (!req_we) begin
            state <= RD_ISSUE;
            cur_addr <= req_addr;
            remain <= req_len;
          end else if (req_len != '0) begin
            state <= FILL;
            cur_addr <= req_addr + 1'b1;
            remain <= req_len - 1'b1;
          end else begin
            cur_addr <= req_addr;
            remain <= req_len;
          end
        end
        FILL: begin
          state <= rem_zero ? IDLE : FILL;
          cur_addr <= cur_next;
          remain <= remain - 1'b1;
        end
        RD_ISSUE: state <= RD_DATA;
        RD_DATA: if (hs) begin
          if (rem_zero) state <= IDLE;
          else begin
            cur_addr <= cur_next;
            remain <= remain - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed vector table plus hand sequences against a behavioural RAM model.
module tb_ram_access_ctrl;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [4:0] req_addr = 0, req_len = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_last, busy, ram_we;
  logic [31:0] rsp_data, ram_w_data, ram_r_data;
  logic [4:0] ram_w_addr, ram_r_addr, ra_q;
  logic [31:0] mem [32];
  int total = 0, bad = 0;

  ram_access_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
  );

  always #5 clk = ~clk;

  // write-first RAM with registered read address
  always @(posedge clk) begin
    if (ram_we) mem[ram_w_addr] <= ram_w_data;
    ra_q <= ram_r_addr;
  end
  assign ram_r_data = mem[ra_q];

  typedef struct {
    logic vld, we; logic [4:0] addr, len; logic [31:0] wd; logic rr;
    logic e_rdy, e_rv, e_last, e_we, e_busy; logic [4:0] e_wa; logic [31:0] e_d;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t v(input logic vld, we, input logic [4:0] addr, len,
                             input logic [31:0] wd, input logic rr, e_rdy, e_rv, e_last, e_we, e_busy,
                             input logic [4:0] e_wa, input logic [31:0] e_d);
    vec_t t;
    t.vld = vld; t.we = we; t.addr = addr; t.len = len; t.wd = wd; t.rr = rr;
    t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_last = e_last; t.e_we = e_we; t.e_busy = e_busy;
    t.e_wa = e_wa; t.e_d = e_d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic vld, we, input logic [4:0] addr, len, input logic [31:0] wd, input logic rr);
    @(negedge clk);
    req_valid = vld; req_we = we; req_addr = addr; req_len = len; req_wdata = wd; rsp_ready = rr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tv.push_back(v(1,1, 3,0,32'hDEADBEEF,1, 1,0,0,1,0, 3,0));
    tv.push_back(v(1,0, 3,0,0,1,            1,0,0,0,0, 0,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,0,0,0,1, 0,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,1,1,0,1, 0,32'hDEADBEEF));
    tv.push_back(v(1,1,30,3,32'hA5A5,1,     1,0,0,1,0,30,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,0,0,1,1,31,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,0,0,1,1, 0,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,0,0,1,1, 1,0));
    tv.push_back(v(1,0,30,3,0,1,            1,0,0,0,0, 0,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,0,0,0,1, 0,0));
    tv.push_back(v(0,0, 0,0,0,1,            0,1,0,0,1, 0,32'hA5A5));
    tv.push_back(v(0,0, 0,0,0,1,            0,1,0,0,1, 0,32'hA5A5));
    tv.push_back(v(0,0, 0,0,0,1,            0,1,0,0,1, 0,32'hA5A5));
    tv.push_back(v(0,0, 0,0,0,1,            0,1,1,0,1, 0,32'hA5A5));
    tv.push_back(v(0,0, 0,0,0,1,            1,0,0,0,0, 0,0));

    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ram_we", 32'(ram_we), 0);
    chk("reset rsp_last", 32'(rsp_last), 0);
    rst = 0;
    #1 chk("reset req_ready", 32'(req_ready), 1);

    foreach (tv[i]) begin
      drv(tv[i].vld, tv[i].we, tv[i].addr, tv[i].len, tv[i].wd, tv[i].rr);
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rv));
      chk($sformatf("v%0d rsp_last", i), 32'(rsp_last), 32'(tv[i].e_last));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(tv[i].e_we));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].e_busy));
      if (tv[i].e_we) chk($sformatf("v%0d ram_w_addr", i), 32'(ram_w_addr), 32'(tv[i].e_wa));
      if (tv[i].e_rv) chk($sformatf("v%0d rsp_data", i), rsp_data, tv[i].e_d);
    end

    // preload mem[i] = i with back-to-back single writes
    for (int i = 0; i < 32; i++) begin
      drv(1, 1, 5'(i), 0, 32'(i), 1);
      if (i == 31) chk("preload req_ready", 32'(req_ready), 1);
    end

    // streaming read of all 32 words
    drv(1, 0, 0, 31, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("stream issue rsp_valid", 32'(rsp_valid), 0);
    for (int i = 0; i < 32; i++) begin
      drv(0, 0, 0, 0, 0, 1);
      chk($sformatf("stream b%0d valid", i), 32'(rsp_valid), 1);
      chk($sformatf("stream b%0d data", i), rsp_data, 32'(i));
      chk($sformatf("stream b%0d last", i), 32'(rsp_last), 32'(i == 31));
    end
    drv(0, 0, 0, 0, 0, 1);
    chk("stream end busy", 32'(busy), 0);

    // backpressure on beat 1
    drv(1, 0, 4, 2, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("bp b0 data", rsp_data, 4);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      chk($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 1);
      chk($sformatf("bp hold%0d data", i), rsp_data, 5);
    end
    drv(0, 0, 0, 0, 0, 1);
    chk("bp b1 data", rsp_data, 5);
    chk("bp b1 last", 32'(rsp_last), 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("bp b2 data", rsp_data, 6);
    chk("bp b2 last", 32'(rsp_last), 1);

    // asynchronous reset in the middle of a len-7 read
    drv(1, 0, 0, 7, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("abort pre valid", 32'(rsp_valid), 1);
    rst = 1;
    #1;
    chk("abort rsp_valid", 32'(rsp_valid), 0);
    chk("abort busy", 32'(busy), 0);
    @(negedge clk);
    rst = 0;
    #1 chk("abort req_ready", 32'(req_ready), 1);
    drv(1, 0, 9, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("after abort issue valid", 32'(rsp_valid), 0);
    drv(0, 0, 0, 0, 0, 1);
    chk("after abort data", rsp_data, 9);
    chk("after abort last", 32'(rsp_last), 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("after abort idle valid", 32'(rsp_valid), 0);

    // write held while a read burst is active
    drv(1, 0, 0, 2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 10, 0, 32'h1234, 1);
      chk($sformatf("gate c%0d req_ready", i), 32'(req_ready), 0);
      chk($sformatf("gate c%0d ram_we", i), 32'(ram_we), 0);
    end
    chk("gate last beat", 32'(rsp_last), 1);
    chk("gate mem untouched", mem[10], 10);
    drv(1, 1, 10, 0, 32'h1234, 1);
    chk("gate accept ready", 32'(req_ready), 1);
    chk("gate accept we", 32'(ram_we), 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("gate mem written", mem[10], 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
